// File: rtl/litedram_cmd_pkg.sv
// Shared command types for the bank command path: the per-bank command record,
// the read/write direction FSM states and an ACTIVATE decode helper.
package litedram_cmd_pkg;

  localparam int CMD_A_W = 14;

  typedef struct packed {
    logic [CMD_A_W-1:0] a;
    logic               ras;
    logic               cas;
    logic               we;
    logic               is_cmd;
    logic               is_read;
    logic               is_write;
  } cmd_t;

  typedef enum logic [1:0] {
    RD  = 2'd0,
    WR  = 2'd1,
    RTW = 2'd2,
    WTR = 2'd3
  } arb_state_t;

  function automatic logic is_activate(cmd_t c);
    return c.ras & ~c.cas & ~c.we;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts just after last_i and
// wraps; the first requester found wins. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N = 8,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] last_i,
  output logic [N-1:0]     grant_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk last_i+1 .. last_i+N (mod N) and grant the first active request.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(last_i) + k) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Bank command arbiter: picks one bank-machine command per cycle (round-robin),
// groups reads and writes into direction phases separated by turnaround gaps,
// and registers the chosen command onto the PHY command bus.
// Optional: define BANK_CMD_ARBITER_TRRD_EN to enforce a minimum ACTIVATE spacing.
module bank_cmd_arbiter
  import litedram_cmd_pkg::*;
#(
  parameter int NBANKS = 8,
  parameter int ADDR_W = 14,
  parameter int BA_W   = 3,
  parameter int TRTW   = 4,
  parameter int TWTR   = 6,
  parameter int TRRD   = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NBANKS-1:0]        cmd_valid,
  output logic [NBANKS-1:0]        cmd_ready,
  input  logic [NBANKS*ADDR_W-1:0] cmd_a,
  input  logic [NBANKS-1:0]        cmd_ras,
  input  logic [NBANKS-1:0]        cmd_cas,
  input  logic [NBANKS-1:0]        cmd_we,
  input  logic [NBANKS-1:0]        cmd_is_cmd,
  input  logic [NBANKS-1:0]        cmd_is_read,
  input  logic [NBANKS-1:0]        cmd_is_write,
  output logic                     phy_cs_n,
  output logic                     phy_ras_n,
  output logic                     phy_cas_n,
  output logic                     phy_we_n,
  output logic [ADDR_W-1:0]        phy_address,
  output logic [BA_W-1:0]          phy_bank,
  output logic                     phy_rddata_en,
  output logic                     phy_wrdata_en
);

  localparam int PTR_W   = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int CNT_MAX = (TRTW > TWTR) ? TRTW : TWTR;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The command record has a fixed address field, so the address width must match it.
  if (ADDR_W != CMD_A_W || NBANKS < 1 || NBANKS > (1 << BA_W) ||
      TRTW < 1 || TWTR < 1 || TRRD < 1) begin : g_bad_cfg
    $error("bank_cmd_arbiter: unsupported parameter set");
  end

  cmd_t             cmds [NBANKS];
  arb_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] last_q;
  logic [NBANKS-1:0] elig, grant, act_blk;
  logic [PTR_W-1:0] sel_idx;
  logic             any_rd, any_wr, xfer;

  // Unpack the flat per-bank buses into command records.
  always_comb begin
    for (int i = 0; i < NBANKS; i++) begin
      cmds[i].a        = cmd_a[i*ADDR_W +: ADDR_W];
      cmds[i].ras      = cmd_ras[i];
      cmds[i].cas      = cmd_cas[i];
      cmds[i].we       = cmd_we[i];
      cmds[i].is_cmd   = cmd_is_cmd[i];
      cmds[i].is_read  = cmd_is_read[i];
      cmds[i].is_write = cmd_is_write[i];
    end
  end

`ifdef BANK_CMD_ARBITER_TRRD_EN
  localparam int RRD_W = $clog2(TRRD + 1);
  logic [RRD_W-1:0] rrd_q;

  // Block requesters presenting an ACTIVATE while the ACT-to-ACT window is open.
  always_comb begin
    act_blk = '0;
    for (int i = 0; i < NBANKS; i++)
      act_blk[i] = (rrd_q != '0) && is_activate(cmds[i]);
  end

  // ACT-to-ACT spacing counter: reload on every accepted ACTIVATE, else count down.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rrd_q <= '0;
    end else if (xfer && is_activate(cmds[sel_idx])) begin
      rrd_q <= RRD_W'(TRRD - 1);
    end else if (rrd_q != '0) begin
      rrd_q <= rrd_q - RRD_W'(1);
    end
  end
`else
  assign act_blk = '0;
`endif

  // Eligibility per direction phase; activates/precharges ride in either phase.
  always_comb begin
    elig   = '0;
    any_rd = 1'b0;
    any_wr = 1'b0;
    for (int i = 0; i < NBANKS; i++) begin
      if (state_q == RD)
        elig[i] = cmd_valid[i] & ~act_blk[i] & (cmds[i].is_cmd | cmds[i].is_read);
      else if (state_q == WR)
        elig[i] = cmd_valid[i] & ~act_blk[i] & (cmds[i].is_cmd | cmds[i].is_write);
      any_rd = any_rd | (cmd_valid[i] & cmds[i].is_read);
      any_wr = any_wr | (cmd_valid[i] & cmds[i].is_write);
    end
  end

  rr_arbiter #(.N(NBANKS)) u_rr (
    .req_i   (elig),
    .last_i  (last_q),
    .grant_o (grant)
  );

  // Encode the one-hot grant into a bank index.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NBANKS; i++)
      if (grant[i]) sel_idx = PTR_W'(i);
  end

  // Reset is asynchronous, so handshakes are suppressed for its whole duration.
  assign cmd_ready = sys_rst ? '0 : grant;
  assign xfer      = |grant;

  // Direction FSM, turnaround counter, round-robin pointer and registered PHY command.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= RD;
      cnt_q         <= '0;
      last_q        <= PTR_W'(NBANKS - 1);
      phy_cs_n      <= 1'b1;
      phy_ras_n     <= 1'b1;
      phy_cas_n     <= 1'b1;
      phy_we_n      <= 1'b1;
      phy_address   <= '0;
      phy_bank      <= '0;
      phy_rddata_en <= 1'b0;
      phy_wrdata_en <= 1'b0;
    end else begin
      case (state_q)
        RD: if (elig == '0 && any_wr) begin
          state_q <= RTW;
          cnt_q   <= CNT_W'(TRTW - 1);
        end
        WR: if (elig == '0 && any_rd) begin
          state_q <= WTR;
          cnt_q   <= CNT_W'(TWTR - 1);
        end
        RTW: if (cnt_q == '0) state_q <= WR;
             else cnt_q <= cnt_q - CNT_W'(1);
        WTR: if (cnt_q == '0) state_q <= RD;
             else cnt_q <= cnt_q - CNT_W'(1);
        default: state_q <= RD;
      endcase

      if (xfer) begin
        last_q        <= sel_idx;
        phy_cs_n      <= 1'b0;
        phy_ras_n     <= ~cmds[sel_idx].ras;
        phy_cas_n     <= ~cmds[sel_idx].cas;
        phy_we_n      <= ~cmds[sel_idx].we;
        phy_address   <= cmds[sel_idx].a;
        phy_bank      <= BA_W'(sel_idx);
        phy_rddata_en <= cmds[sel_idx].is_read;
        phy_wrdata_en <= cmds[sel_idx].is_write;
      end else begin
        phy_cs_n      <= 1'b1;
        phy_ras_n     <= 1'b1;
        phy_cas_n     <= 1'b1;
        phy_we_n      <= 1'b1;
        phy_address   <= '0;
        phy_bank      <= '0;
        phy_rddata_en <= 1'b0;
        phy_wrdata_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Directed bench for bank_cmd_arbiter: reset, round-robin order, wrap-around,
// read/write turnaround gaps, precharge during a pending switch, ACTIVATE spacing
// and fairness with all banks requesting.
module tb_bank_cmd_arbiter;

  localparam int NB = 8;
  localparam int AW = 14;
  localparam int BW = 3;

  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_ACT = 2;
  localparam int K_PRE = 3;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic [NB-1:0]  cmd_valid, cmd_ready;
  logic [NB*AW-1:0] cmd_a;
  logic [NB-1:0]  cmd_ras, cmd_cas, cmd_we, cmd_is_cmd, cmd_is_read, cmd_is_write;
  logic           phy_cs_n, phy_ras_n, phy_cas_n, phy_we_n;
  logic [AW-1:0]  phy_address;
  logic [BW-1:0]  phy_bank;
  logic           phy_rddata_en, phy_wrdata_en;

  int checks = 0;
  int errors = 0;

  bank_cmd_arbiter #(
    .NBANKS(NB), .ADDR_W(AW), .BA_W(BW), .TRTW(4), .TWTR(6), .TRRD(4)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a         (cmd_a),
    .cmd_ras       (cmd_ras),
    .cmd_cas       (cmd_cas),
    .cmd_we        (cmd_we),
    .cmd_is_cmd    (cmd_is_cmd),
    .cmd_is_read   (cmd_is_read),
    .cmd_is_write  (cmd_is_write),
    .phy_cs_n      (phy_cs_n),
    .phy_ras_n     (phy_ras_n),
    .phy_cas_n     (phy_cas_n),
    .phy_we_n      (phy_we_n),
    .phy_address   (phy_address),
    .phy_bank      (phy_bank),
    .phy_rddata_en (phy_rddata_en),
    .phy_wrdata_en (phy_wrdata_en)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    cmd_valid = '0; cmd_a = '0; cmd_ras = '0; cmd_cas = '0; cmd_we = '0;
    cmd_is_cmd = '0; cmd_is_read = '0; cmd_is_write = '0;
  endtask

  task automatic drop(input int b);
    cmd_valid[b] = 1'b0; cmd_ras[b] = 1'b0; cmd_cas[b] = 1'b0; cmd_we[b] = 1'b0;
    cmd_is_cmd[b] = 1'b0; cmd_is_read[b] = 1'b0; cmd_is_write[b] = 1'b0;
    cmd_a[b*AW +: AW] = '0;
  endtask

  task automatic set_cmd(input int b, input int kind, input logic [AW-1:0] a);
    drop(b);
    cmd_valid[b] = 1'b1;
    cmd_a[b*AW +: AW] = a;
    case (kind)
      K_RD:  begin cmd_cas[b] = 1'b1; cmd_is_read[b] = 1'b1; end
      K_WR:  begin cmd_cas[b] = 1'b1; cmd_we[b] = 1'b1; cmd_is_write[b] = 1'b1; end
      K_ACT: begin cmd_ras[b] = 1'b1; cmd_is_cmd[b] = 1'b1; end
      default: begin cmd_ras[b] = 1'b1; cmd_we[b] = 1'b1; cmd_is_cmd[b] = 1'b1; end
    endcase
  endtask

  // Advance one cycle; banks accepted in the cycle just ending withdraw their request.
  task automatic tick();
    logic [NB-1:0] acc;
    acc = cmd_ready;
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < NB; i++) if (acc[i]) drop(i);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".cs_n"},  phy_cs_n, 1);
    chk({tag, ".ras_n"}, phy_ras_n, 1);
    chk({tag, ".cas_n"}, phy_cas_n, 1);
    chk({tag, ".we_n"},  phy_we_n, 1);
    chk({tag, ".rden"},  phy_rddata_en, 0);
    chk({tag, ".wren"},  phy_wrdata_en, 0);
    chk({tag, ".addr"},  phy_address, 0);
    chk({tag, ".bank"},  phy_bank, 0);
    chk({tag, ".ready"}, cmd_ready, 0);
  endtask

  initial begin
    sys_rst = 1'b1;
    clear_all();
    repeat (3) @(posedge sys_clk);
    #3;
    chk_idle("rst_init");
    sys_rst = 1'b0;

    // Round-robin among banks 0, 3, 5 reads.
    tick();
    set_cmd(0, K_RD, 14'h100); set_cmd(3, K_RD, 14'h103); set_cmd(5, K_RD, 14'h105);
    #2;
    chk("rr.c0.ready", cmd_ready, 8'h01);
    tick(); #2;
    chk("rr.c1.ready", cmd_ready, 8'h08);
    chk("rr.c1.bank",  phy_bank, 0);
    chk("rr.c1.rden",  phy_rddata_en, 1);
    chk("rr.c1.cs_n",  phy_cs_n, 0);
    chk("rr.c1.cas_n", phy_cas_n, 0);
    chk("rr.c1.ras_n", phy_ras_n, 1);
    chk("rr.c1.we_n",  phy_we_n, 1);
    chk("rr.c1.addr",  phy_address, 14'h100);
    tick(); #2;
    chk("rr.c2.ready", cmd_ready, 8'h20);
    chk("rr.c2.bank",  phy_bank, 3);
    chk("rr.c2.rden",  phy_rddata_en, 1);
    tick(); #2;
    chk("rr.c3.ready", cmd_ready, 8'h00);
    chk("rr.c3.bank",  phy_bank, 5);
    chk("rr.c3.addr",  phy_address, 14'h105);
    chk("rr.c3.cas_n", phy_cas_n, 0);
    tick(); #2;
    chk("rr.c4.cs_n",  phy_cs_n, 1);
    chk("rr.c4.rden",  phy_rddata_en, 0);

    // Reset asserted while a command is on the bus and another is pending.
    tick();
    set_cmd(1, K_RD, 14'h011); set_cmd(2, K_RD, 14'h012);
    #2;
    chk("mid.c0.ready", cmd_ready, 8'h02);
    tick(); #2;
    chk("mid.c1.ready", cmd_ready, 8'h04);
    chk("mid.c1.cs_n",  phy_cs_n, 0);
    sys_rst = 1'b1;
    #1;
    chk_idle("mid_rst");
    #1;
    sys_rst = 1'b0;
    clear_all();

    // After reset last_grant is 7: bank 1 wins before bank 7.
    tick();
    set_cmd(1, K_RD, 14'h021); set_cmd(7, K_RD, 14'h027);
    #2;
    chk("wrap.c0.ready", cmd_ready, 8'h02);
    tick(); #2;
    chk("wrap.c1.ready", cmd_ready, 8'h80);
    chk("wrap.c1.bank",  phy_bank, 1);
    tick(); #2;
    chk("wrap.c2.ready", cmd_ready, 8'h00);
    chk("wrap.c2.bank",  phy_bank, 7);
    chk("wrap.c2.rden",  phy_rddata_en, 1);

    // Read-to-write turnaround with a lone write on bank 2.
    tick();
    set_cmd(2, K_WR, 14'h222);
    #2;
    chk("rtw.c0.ready", cmd_ready, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      tick(); #2;
      chk($sformatf("rtw.c%0d.ready", c), cmd_ready, 8'h00);
      chk($sformatf("rtw.c%0d.cs_n", c),  phy_cs_n, 1);
    end
    tick(); #2;
    chk("rtw.c5.ready", cmd_ready, 8'h04);
    tick(); #2;
    chk("rtw.c6.we_n",  phy_we_n, 0);
    chk("rtw.c6.cas_n", phy_cas_n, 0);
    chk("rtw.c6.ras_n", phy_ras_n, 1);
    chk("rtw.c6.wren",  phy_wrdata_en, 1);
    chk("rtw.c6.rden",  phy_rddata_en, 0);
    chk("rtw.c6.bank",  phy_bank, 2);
    chk("rtw.c6.addr",  phy_address, 14'h222);

    // In WR: precharge on bank 4 goes first, then write-to-read gap, then the read.
    tick();
    set_cmd(4, K_PRE, 14'h400); set_cmd(6, K_RD, 14'h066);
    #2;
    chk("wtr.c0.ready", cmd_ready, 8'h10);
    tick(); #2;
    chk("wtr.c1.ready", cmd_ready, 8'h00);
    chk("wtr.c1.ras_n", phy_ras_n, 0);
    chk("wtr.c1.cas_n", phy_cas_n, 1);
    chk("wtr.c1.we_n",  phy_we_n, 0);
    chk("wtr.c1.bank",  phy_bank, 4);
    chk("wtr.c1.rden",  phy_rddata_en, 0);
    chk("wtr.c1.wren",  phy_wrdata_en, 0);
    for (int c = 2; c <= 7; c++) begin
      tick(); #2;
      chk($sformatf("wtr.c%0d.ready", c), cmd_ready, 8'h00);
    end
    tick(); #2;
    chk("wtr.c8.ready", cmd_ready, 8'h40);
    tick(); #2;
    chk("wtr.c9.bank",  phy_bank, 6);
    chk("wtr.c9.rden",  phy_rddata_en, 1);

    // Two ACTIVATEs on banks 0 and 1 (last_grant is 6).
    tick();
    set_cmd(0, K_ACT, 14'h0A0); set_cmd(1, K_ACT, 14'h0A1);
    #2;
    chk("act.c0.ready", cmd_ready, 8'h01);
    tick(); #2;
    chk("act.c1.ras_n", phy_ras_n, 0);
    chk("act.c1.cas_n", phy_cas_n, 1);
    chk("act.c1.we_n",  phy_we_n, 1);
    chk("act.c1.bank",  phy_bank, 0);
`ifdef BANK_CMD_ARBITER_TRRD_EN
    chk("act.c1.ready", cmd_ready, 8'h00);
    tick(); #2;
    chk("act.c2.ready", cmd_ready, 8'h00);
    tick(); #2;
    chk("act.c3.ready", cmd_ready, 8'h00);
    tick(); #2;
    chk("act.c4.ready", cmd_ready, 8'h02);
`else
    chk("act.c1.ready", cmd_ready, 8'h02);
`endif
    tick(); #2;
    chk("act.next.bank", phy_bank, 1);
    chk("act.next.ras_n", phy_ras_n, 0);

    // All banks request continuously: one grant each per eight, starting after bank 1.
    tick();
    for (int b = 0; b < NB; b++) set_cmd(b, K_RD, 14'(b));
    for (int k = 0; k < NB; k++) begin
      logic [31:0] exp_rdy;
      int b;
      b = (2 + k) % NB;
      exp_rdy = 32'd1 << b;
      #2;
      chk($sformatf("fair.k%0d.ready", k), cmd_ready, exp_rdy);
      tick();
      set_cmd(b, K_RD, 14'(b));
    end
    clear_all();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
